uart_echo_responder: RTL and testbench

Far-end UART responder for the serial loopback link: receives 8N1 frames on a serial input, buffers each good byte in a small FIFO, and retransmits it (optionally XOR-masked) on its own serial output. It lets the bench close a loop through a remote device model rather than a wire, and gives the link framing-error and overflow visibility.

---
 rtl/uart_echo_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_echo_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_echo_responder
// Brief    : 8N1 UART receiver -> byte FIFO -> (XOR-masked) UART echo transmitter
// Revision : 1.0
// ============================================================================
module uart_echo_responder #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] ECHO_XOR     = 8'h00
) (
    input  logic                             i_clock,
    input  logic                             i_reset_n,
    input  logic                             i_rx_serial,
    input  logic                             i_tx_pause,
    input  logic                             i_clear_errors,
    output logic                             o_tx_serial,
    output logic                             o_tx_active,
    output logic                             o_rx_dv,
    output logic [7:0]                       o_rx_byte,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level,
    output logic                             o_framing_error,
    output logic                             o_overflow
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [c_lvl_w-1:0] c_full      = c_lvl_w'(FIFO_DEPTH);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [1:0] c_tx_idle  = 2'd0;
    localparam logic [1:0] c_tx_start = 2'd1;
    localparam logic [1:0] c_tx_data  = 2'd2;
    localparam logic [1:0] c_tx_stop  = 2'd3;

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic [1:0]         r_rx_state;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               r_rx_dv;
    logic [7:0]         r_rx_byte;
    logic               r_framing_error;
    logic               r_overflow;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;

    logic [1:0]         r_tx_state;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_tx_data;
    logic               r_tx_serial;
    logic               r_tx_active;

    logic w_stop_sample;
    logic w_good_byte;
    logic w_bad_stop;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_stop_sample = (r_rx_state == c_rx_stop) && (r_rx_cnt == c_bit_last);
    assign w_good_byte   = w_stop_sample && r_rx_sync;
    assign w_bad_stop    = w_stop_sample && !r_rx_sync;
    assign w_pop         = (r_tx_state == c_tx_idle) && (r_level != '0) && !i_tx_pause;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign w_push        = w_good_byte && ((r_level != c_full) || w_pop);
    assign w_drop        = w_good_byte && !w_push;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx_serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_state <= c_rx_idle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                c_rx_idle: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    if (!r_rx_sync) r_rx_state <= c_rx_start;
                end
                c_rx_start: begin
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_sync ? c_rx_idle : c_rx_data;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                c_rx_data: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= c_rx_stop;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                c_rx_stop: begin
                    if (r_rx_cnt == c_bit_last) r_rx_state <= c_rx_idle;
                    else                        r_rx_cnt   <= r_rx_cnt + c_cnt_w'(1);
                end
                default: r_rx_state <= c_rx_idle;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_dv         <= 1'b0;
            r_rx_byte       <= '0;
            r_framing_error <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_rx_dv <= w_push;
            if (w_push) r_rx_byte <= r_rx_shift;
            if (w_bad_stop)          r_framing_error <= 1'b1;
            else if (i_clear_errors) r_framing_error <= 1'b0;
            if (w_drop)              r_overflow <= 1'b1;
            else if (i_clear_errors) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_push && !w_pop)      r_level <= r_level + c_lvl_w'(1);
            else if (!w_push && w_pop) r_level <= r_level - c_lvl_w'(1);
        end
    end

    // Line and active flag are registered from the current state, so each
    // bit appears one edge after its state is entered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_state  <= c_tx_idle;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_data   <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
        end else begin
            case (r_tx_state)
                c_tx_idle: begin
                    r_tx_serial <= 1'b1;
                    r_tx_active <= 1'b0;
                    r_tx_cnt    <= '0;
                    r_tx_bit    <= '0;
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr] ^ ECHO_XOR;
                        r_tx_state <= c_tx_start;
                    end
                end
                c_tx_start: begin
                    r_tx_serial <= 1'b0;
                    r_tx_active <= 1'b1;
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= c_tx_data;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                    end
                end
                c_tx_data: begin
                    r_tx_serial <= r_tx_data[r_tx_bit];
                    r_tx_active <= 1'b1;
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) r_tx_state <= c_tx_stop;
                        else                  r_tx_bit   <= r_tx_bit + 3'd1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                    end
                end
                c_tx_stop: begin
                    r_tx_serial <= 1'b1;
                    r_tx_active <= 1'b1;
                    if (r_tx_cnt == c_bit_last) r_tx_state <= c_tx_idle;
                    else                        r_tx_cnt   <= r_tx_cnt + c_cnt_w'(1);
                end
                default: r_tx_state <= c_tx_idle;
            endcase
        end
    end

    assign o_tx_serial     = r_tx_serial;
    assign o_tx_active     = r_tx_active;
    assign o_rx_dv         = r_rx_dv;
    assign o_rx_byte       = r_rx_byte;
    assign o_fifo_level    = r_level;
    assign o_framing_error = r_framing_error;
    assign o_overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_responder
// Brief    : Directed bench: one responder with a 4-deep FIFO, one with mask FF.
// Revision : 1.0
// ============================================================================
module tb_uart_echo_responder;

    localparam int c_cpb = 87;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic       rst_n, rx_a, rx_b, pause_a, pause_b, clr_a, clr_b;
    logic       tx_a, act_a, dv_a, fe_a, ov_a;
    logic       tx_b, act_b, dv_b, fe_b, ov_b;
    logic [7:0] byte_a, byte_b;
    logic [2:0] lvl_a;
    logic [4:0] lvl_b;

    uart_echo_responder #(.CLKS_PER_BIT(c_cpb), .FIFO_DEPTH(4), .ECHO_XOR(8'h00)) u_dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_serial(rx_a), .i_tx_pause(pause_a),
        .i_clear_errors(clr_a), .o_tx_serial(tx_a), .o_tx_active(act_a), .o_rx_dv(dv_a),
        .o_rx_byte(byte_a), .o_fifo_level(lvl_a), .o_framing_error(fe_a), .o_overflow(ov_a)
    );

    uart_echo_responder #(.CLKS_PER_BIT(c_cpb), .FIFO_DEPTH(16), .ECHO_XOR(8'hFF)) u_dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_rx_serial(rx_b), .i_tx_pause(pause_b),
        .i_clear_errors(clr_b), .o_tx_serial(tx_b), .o_tx_active(act_b), .o_rx_dv(dv_b),
        .o_rx_byte(byte_b), .o_fifo_level(lvl_b), .o_framing_error(fe_b), .o_overflow(ov_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int dv_cnt_a = 0;
    int dv_cnt_b = 0;

    always @(negedge clk) begin
        if (dv_a === 1'b1) dv_cnt_a = dv_cnt_a + 1;
        if (dv_b === 1'b1) dv_cnt_b = dv_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // A bad stop bit is held low only past the receiver's stop sample point.
    task automatic send_frame(input bit sel, input logic [7:0] b, input bit stop_ok);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 9 && !stop_ok) begin
                set_rx(sel, 1'b0);
                repeat (c_cpb / 2 + 7) @(negedge clk);
                set_rx(sel, 1'b1);
                repeat (c_cpb - c_cpb / 2 - 8) @(negedge clk);
            end else begin
                set_rx(sel, bits[k]);
                repeat (c_cpb - 1) @(negedge clk);
            end
        end
    endtask

    task automatic recv_frame(input bit sel, input int limit, output bit got,
                              output logic [7:0] data, output int len,
                              output int waited, output bit shape_ok);
        logic       line;
        logic       act;
        logic [9:0] bits;
        got = 1'b0; data = '0; len = 0; waited = 0; shape_ok = 1'b0;
        bits = '1;
        line = 1'b1;
        while (waited < limit) begin
            @(negedge clk);
            line = sel ? tx_b : tx_a;
            if (line === 1'b0) break;
            waited++;
        end
        if (line !== 1'b0) return;
        got = 1'b1;
        for (int j = 0; j < 20 * c_cpb; j++) begin
            line = sel ? tx_b : tx_a;
            act  = sel ? act_b : act_a;
            if ((j % c_cpb) == c_cpb / 2 && (j / c_cpb) < 10) bits[j / c_cpb] = line;
            if (act !== 1'b1) break;
            len++;
            @(negedge clk);
        end
        data     = bits[8:1];
        shape_ok = (bits[0] === 1'b0) && (bits[9] === 1'b1);
    endtask

    bit         got;
    bit         shape;
    logic [7:0] data;
    int         len;
    int         waited;
    int         d0;

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        pause_a = 1'b0; pause_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx_serial", tx_a, 1);
        check("rst_tx_active", act_a, 0);
        check("rst_rx_dv", dv_a, 0);
        check("rst_rx_byte", byte_a, 0);
        check("rst_level", lvl_a, 0);
        check("rst_framing", fe_a, 0);
        check("rst_overflow", ov_a, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte echo
        d0 = dv_cnt_a;
        fork
            send_frame(1'b0, 8'hAB, 1'b1);
            recv_frame(1'b0, 3000, got, data, len, waited, shape);
        join
        check("single_got", got, 1);
        check("single_echo", data, 8'hAB);
        check("single_shape", shape, 1);
        check("single_active_len", len, 10 * c_cpb);
        check("single_dv_count", dv_cnt_a - d0, 1);
        check("single_rx_byte", byte_a, 8'hAB);
        check("single_level", lvl_a, 0);

        // XOR mask on the second responder
        d0 = dv_cnt_b;
        fork
            send_frame(1'b1, 8'h3C, 1'b1);
            recv_frame(1'b1, 3000, got, data, len, waited, shape);
        join
        check("xor_got", got, 1);
        check("xor_echo", data, 8'hC3);
        check("xor_rx_byte", byte_b, 8'h3C);
        check("xor_dv_count", dv_cnt_b - d0, 1);

        // Overflow with TX paused
        pause_a = 1'b1;
        d0 = dv_cnt_a;
        for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 1'b1);
        repeat (10) @(negedge clk);
        check("ovf_level", lvl_a, 4);
        check("ovf_flag", ov_a, 1);
        check("ovf_dv_count", dv_cnt_a - d0, 4);
        check("ovf_rx_byte", byte_a, 8'h04);
        check("ovf_paused_line", tx_a, 1);
        check("ovf_framing", fe_a, 0);
        pause_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            recv_frame(1'b0, 100, got, data, len, waited, shape);
            check("ovf_echo_got", got, 1);
            check("ovf_echo_byte", data, 8'(i));
            check("ovf_echo_gap", waited, (i == 1) ? 1 : 0);
            check("ovf_echo_len", len, 10 * c_cpb);
        end
        recv_frame(1'b0, 2 * 10 * c_cpb, got, data, len, waited, shape);
        check("ovf_no_fifth", got, 0);
        check("ovf_level_drained", lvl_a, 0);

        // Framing error, then clear, then normal echo
        d0 = dv_cnt_a;
        send_frame(1'b0, 8'h55, 1'b0);
        recv_frame(1'b0, 300, got, data, len, waited, shape);
        check("fe_no_echo", got, 0);
        check("fe_flag", fe_a, 1);
        check("fe_no_dv", dv_cnt_a - d0, 0);
        check("fe_level", lvl_a, 0);
        check("fe_ovf_sticky", ov_a, 1);
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        check("clr_framing", fe_a, 0);
        check("clr_overflow", ov_a, 0);
        fork
            send_frame(1'b0, 8'h5A, 1'b1);
            recv_frame(1'b0, 3000, got, data, len, waited, shape);
        join
        check("after_fe_got", got, 1);
        check("after_fe_echo", data, 8'h5A);
        check("after_fe_dv", dv_cnt_a - d0, 1);

        // Glitch on the RX line
        d0 = dv_cnt_a;
        @(negedge clk); rx_a = 1'b0;
        repeat (20) @(negedge clk);
        rx_a = 1'b1;
        repeat (150) @(negedge clk);
        check("glitch_no_dv", dv_cnt_a - d0, 0);
        check("glitch_framing", fe_a, 0);
        check("glitch_overflow", ov_a, 0);
        check("glitch_level", lvl_a, 0);
        check("glitch_line", tx_a, 1);

        // Reset in the middle of an echo
        send_frame(1'b0, 8'hF0, 1'b1);
        repeat (150) @(negedge clk);
        check("midrst_active_before", act_a, 1);
        check("midrst_line_before", tx_a, 0);
        #20 rst_n = 1'b0;
        #1;
        check("midrst_line", tx_a, 1);
        check("midrst_active", act_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_level", lvl_a, 0);
        check("midrst_rx_byte", byte_a, 0);
        recv_frame(1'b0, 2000, got, data, len, waited, shape);
        check("midrst_no_residual", got, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #6000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
